// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART datapath.
//   rx_state_t    - receive framer state encoding
//   DATA_BITS_DEF - default number of data bits per frame
//   LINE_IDLE     - level of the serial line when no frame is in flight
package uart_pkg;

    localparam int   DATA_BITS_DEF = 8;
    localparam logic LINE_IDLE     = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

endpackage

// File: rtl/sync_bit.sv
// sync_bit: multi-stage flip-flop synchronizer for a single asynchronous bit.
//   Parameters: STAGES (>= 2), RESET_VAL (value of every stage in reset)
//   clk   in  - destination clock
//   rst_n in  - asynchronous active-low reset
//   d     in  - asynchronous input
//   q     out - synchronized output, STAGES clk cycles behind d
module sync_bit #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART receive framer.
// Detects a start bit on rxd, enables the baud generator for the length of
// the frame, samples one bit per bpsClk pulse and reports the received word.
// Optional feature macro: UART_RX_PARITY_EN (one even-parity bit after data).
//
// Ports:
//   clk         in  - system clock, rising edge
//   reset       in  - asynchronous active-low reset
//   rxd         in  - serial line (asynchronous, idles high)
//   bpsClk      in  - one-cycle pulse at the centre of each bit period
//   countEnable out - baud generator enable, high while a frame is in flight
//   rxData      out - last good word, held between frames
//   rxValid     out - one-cycle strobe: new rxData
//   frameErr    out - one-cycle strobe: stop bit sampled low
//   parityErr   out - one-cycle strobe: parity mismatch (0 without parity)
//   busy        out - high whenever the FSM is not idle
//   dbg_state   out - current FSM state, for observation only
//
// Baud handshake: countEnable is a level request; while it is high the
// generator returns a one-cycle bpsClk pulse per bit, the first one half a
// bit after countEnable rises. Dropping countEnable for at least one cycle
// restarts the generator's phase. bpsClk is ignored whenever the FSM is idle.
import uart_pkg::*;

module uart_rx_frame #(
    parameter int DATA_BITS   = DATA_BITS_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxd,
    input  logic                 bpsClk,
    output logic                 countEnable,
    output logic [DATA_BITS-1:0] rxData,
    output logic                 rxValid,
    output logic                 frameErr,
    output logic                 parityErr,
    output logic                 busy,
    output rx_state_t            dbg_state
);

    localparam int                 CNT_W    = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(DATA_BITS - 1);

    logic                 rxd_s;
    logic                 prev_q,  prev_d;
    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q,  data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q,  ferr_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_q,   par_d;
    logic                 perr_q,  perr_d;
`endif
    logic                 fall;

    sync_bit #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (LINE_IDLE)
    ) u_sync (
        .clk   (clk),
        .rst_n (reset),
        .d     (rxd),
        .q     (rxd_s)
    );

    // Only a genuine high-to-low transition starts a frame, so a line stuck
    // low after a break cannot re-trigger until it has gone high again.
    assign fall = prev_q & ~rxd_s;

    always_comb begin
        prev_d  = rxd_s;
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bpsClk) begin
                    if (!rxd_s) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                    end else begin
                        // Line was high again at mid start bit: a glitch.
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (bpsClk) begin
                    // Shift right from the MSB so the first bit lands at bit 0.
                    shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (bpsClk) begin
                    par_d   = rxd_s;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bpsClk) begin
                    if (rxd_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                        // Even parity: data bits plus parity bit XOR to 0.
                        perr_d  = ^shift_q ^ par_q;
`endif
                    end else begin
                        ferr_d  = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q  <= LINE_IDLE;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            prev_q  <= prev_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    // Derived from the state register, so both drop with reset and are
    // already low in the cycle the end-of-frame strobe is visible.
    assign countEnable = (state_q != ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign rxData      = data_q;
    assign rxValid     = valid_q;
    assign frameErr    = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign parityErr   = perr_q;
`else
    assign parityErr   = 1'b0;
`endif
    assign dbg_state   = state_q;

endmodule
